// File: rtl/glove_pkg.sv
// Shared types for the arg-top-3 selection stage.
// Class indices are 5 bits wide, so a frame holds at most 32 classes.
package glove_pkg;
  localparam int CLS_W       = 5;
  localparam int SCORE_W_DEF = 16;

  typedef logic [CLS_W-1:0]              cls_idx_t;
  typedef logic signed [SCORE_W_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;
endpackage

// File: rtl/top3_insert.sv
// Combinational sorted insertion of one (score, index) pair into a three-entry list.
// The list is kept c0 >= c1 >= c2. A new entry moves ahead only when strictly greater, so on ties the earlier index stays in front.
module top3_insert
  import glove_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic signed [SCORE_W-1:0] c0_score,
  input  cls_idx_t                  c0_idx,
  input  logic signed [SCORE_W-1:0] c1_score,
  input  cls_idx_t                  c1_idx,
  input  logic signed [SCORE_W-1:0] c2_score,
  input  cls_idx_t                  c2_idx,
  input  logic signed [SCORE_W-1:0] new_score,
  input  cls_idx_t                  new_idx,
  output logic signed [SCORE_W-1:0] n0_score,
  output cls_idx_t                  n0_idx,
  output logic signed [SCORE_W-1:0] n1_score,
  output cls_idx_t                  n1_idx,
  output logic signed [SCORE_W-1:0] n2_score,
  output cls_idx_t                  n2_idx
);
  logic gt0, gt1, gt2;

  // The list is sorted, so gt0 implies gt1 and gt1 implies gt2.
  assign gt0 = new_score > c0_score;
  assign gt1 = new_score > c1_score;
  assign gt2 = new_score > c2_score;

  always_comb begin
    n0_score = c0_score;
    n0_idx   = c0_idx;
    n1_score = c1_score;
    n1_idx   = c1_idx;
    n2_score = c2_score;
    n2_idx   = c2_idx;
    if (gt0) begin
      n0_score = new_score;
      n0_idx   = new_idx;
    end
    if (gt0) begin
      n1_score = c0_score;
      n1_idx   = c0_idx;
    end else if (gt1) begin
      n1_score = new_score;
      n1_idx   = new_idx;
    end
    if (gt1) begin
      n2_score = c1_score;
      n2_idx   = c1_idx;
    end else if (gt2) begin
      n2_score = new_score;
      n2_idx   = new_idx;
    end
  end
endmodule

// File: rtl/top3_select.sv
// Streaming arg-top-3: one score per valid cycle, publishes the top-3 indices per frame with an o_next pulse.
// Optional TOP3_SELECT_THRESH_EN rejects frames whose best score is below THRESH (pulses o_reject instead).
module top3_select
  import glove_pkg::*;
#(
  parameter int                        N_CLASS = 27,
  parameter int                        SCORE_W = 16,
  parameter logic signed [SCORE_W-1:0] THRESH  = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_valid,
  input  logic signed [SCORE_W-1:0] i_score,
  output logic [CLS_W-1:0]          o_tops      [0:2],
  output logic [CLS_W-1:0]          o_prev_tops [0:2],
  output logic                      o_next,
`ifdef TOP3_SELECT_THRESH_EN
  output logic                      o_reject,
`endif
  output logic                      o_busy
);
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam cls_idx_t                  LAST_IDX  = cls_idx_t'(N_CLASS - 1);

  state_t                    state, state_nxt;
  cls_idx_t                  count;
  logic signed [SCORE_W-1:0] c_score [0:2];
  cls_idx_t                  c_idx   [0:2];
  logic signed [SCORE_W-1:0] n_score [0:2];
  cls_idx_t                  n_idx   [0:2];
  logic                      reject;

  top3_insert #(.SCORE_W(SCORE_W)) u_insert (
    .c0_score (c_score[0]), .c0_idx (c_idx[0]),
    .c1_score (c_score[1]), .c1_idx (c_idx[1]),
    .c2_score (c_score[2]), .c2_idx (c_idx[2]),
    .new_score(i_score),    .new_idx(count),
    .n0_score (n_score[0]), .n0_idx (n_idx[0]),
    .n1_score (n_score[1]), .n1_idx (n_idx[1]),
    .n2_score (n_score[2]), .n2_idx (n_idx[2])
  );

`ifdef TOP3_SELECT_THRESH_EN
  assign reject = c_score[0] < THRESH;
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_SCAN;
      S_SCAN:  if (i_valid && count == LAST_IDX) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);

  // Reset is active-high on i_rst_n.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      o_next <= 1'b0;
`ifdef TOP3_SELECT_THRESH_EN
      o_reject <= 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
        c_score[k]     <= SCORE_MIN;
        c_idx[k]       <= '0;
        o_tops[k]      <= '0;
        o_prev_tops[k] <= '0;
      end
    end else begin
      state  <= state_nxt;
      o_next <= (state == S_DONE) && !reject;
`ifdef TOP3_SELECT_THRESH_EN
      o_reject <= (state == S_DONE) && reject;
`endif
      case (state)
        S_IDLE: if (i_start) begin
          count <= '0;
          for (int k = 0; k < 3; k++) begin
            c_score[k] <= SCORE_MIN;
            c_idx[k]   <= '0;
          end
        end
        S_SCAN: if (i_valid) begin
          count <= count + 1'b1;
          for (int k = 0; k < 3; k++) begin
            c_score[k] <= n_score[k];
            c_idx[k]   <= n_idx[k];
          end
        end
        S_DONE: if (!reject) begin
          for (int k = 0; k < 3; k++) begin
            o_prev_tops[k] <= o_tops[k];
            o_tops[k]      <= c_idx[k];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top3_select.sv
// Directed bench for top3_select: frame results, ties, valid gaps, ignored starts, mid-scan reset.
// Define TOP3_SELECT_THRESH_EN for both RTL and bench to also exercise frame rejection.
module tb_top3_select;
  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic              i_valid;
  logic signed [15:0] i_score;
  logic [4:0]        o_tops      [0:2];
  logic [4:0]        o_prev_tops [0:2];
  logic              o_next;
  logic              o_busy;
`ifdef TOP3_SELECT_THRESH_EN
  logic              o_reject;
`endif

  int checks = 0;
  int errors = 0;
  int next_cnt = 0;
  int sc [0:31];

  top3_select #(.N_CLASS(27), .SCORE_W(16), .THRESH(16'sd10)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_score    (i_score),
    .o_tops     (o_tops),
    .o_prev_tops(o_prev_tops),
    .o_next     (o_next),
`ifdef TOP3_SELECT_THRESH_EN
    .o_reject   (o_reject),
`endif
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_next) next_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_tops(input string tag, input int t0, input int t1, input int t2,
                          input int p0, input int p1, input int p2);
    chk({tag, " tops0"}, 32'(o_tops[0]), t0);
    chk({tag, " tops1"}, 32'(o_tops[1]), t1);
    chk({tag, " tops2"}, 32'(o_tops[2]), t2);
    chk({tag, " prev0"}, 32'(o_prev_tops[0]), p0);
    chk({tag, " prev1"}, 32'(o_prev_tops[1]), p1);
    chk({tag, " prev2"}, 32'(o_prev_tops[2]), p2);
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Feeds sc[0..n-1]; gap cycles also pulse i_start, which must be ignored mid-scan.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        i_valid = 1'b0;
        i_score = 16'sh7fff;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
      end
      i_valid = 1'b1;
      i_score = 16'(sc[i]);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
  endtask

  // Called on the negedge right after the last accept edge; returns on the negedge where o_next is expected.
  task automatic finish_frame(input string tag, input bit accept);
    chk({tag, " next early"}, 32'(o_next), 0);
    chk({tag, " busy done"}, 32'(o_busy), 1);
    @(negedge i_clk);
    chk({tag, " next pulse"}, 32'(o_next), 32'(accept));
`ifdef TOP3_SELECT_THRESH_EN
    chk({tag, " reject"}, 32'(o_reject), 32'(!accept));
`endif
    chk({tag, " busy idle"}, 32'(o_busy), 0);
  endtask

  task automatic next_low(input string tag);
    @(negedge i_clk);
    chk({tag, " next off"}, 32'(o_next), 0);
  endtask

  task automatic load_ascending();
    for (int i = 0; i < 32; i++) sc[i] = i;
  endtask

  task automatic load_second();
    for (int i = 0; i < 32; i++) sc[i] = -50;
    sc[5] = 100; sc[2] = 90; sc[17] = 80;
  endtask

  initial begin
    int n0;
    i_rst_n = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_score = '0;
    repeat (2) @(negedge i_clk);
    chk("rst next", 32'(o_next), 0);
    chk("rst busy", 32'(o_busy), 0);
    chk_tops("rst", 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    @(negedge i_clk);

    // Valid while idle must not start anything.
    i_valid = 1'b1; i_score = 16'sd500;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("idle valid busy", 32'(o_busy), 0);

    load_ascending();
    start_frame();
    chk("scan busy", 32'(o_busy), 1);
    feed(27, 1'b0);
    finish_frame("asc", 1'b1);
    chk_tops("asc", 26, 25, 24, 0, 0, 0);
    next_low("asc");

    load_second();
    start_frame();
    feed(27, 1'b0);
    finish_frame("second", 1'b1);
    chk_tops("second", 5, 2, 17, 26, 25, 24);
    next_low("second");

    for (int i = 0; i < 32; i++) sc[i] = 7;
    start_frame();
    feed(27, 1'b0);
    finish_frame("tie", 1'b1);
    chk_tops("tie", 0, 1, 2, 5, 2, 17);
    next_low("tie");

    load_second();
    start_frame();
    feed(27, 1'b1);
    finish_frame("gaps", 1'b1);
    chk_tops("gaps", 5, 2, 17, 0, 1, 2);
    // Start coincident with o_next is accepted.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("b2b next off", 32'(o_next), 0);
    chk("b2b busy", 32'(o_busy), 1);

    load_ascending();
    feed(10, 1'b1);
    #1 n0 = next_cnt;
    i_rst_n = 1'b1;
    #1;
    chk("abort busy", 32'(o_busy), 0);
    chk("abort next", 32'(o_next), 0);
    chk_tops("abort", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (30) @(negedge i_clk);
    #1 chk("abort no next", 32'(next_cnt), 32'(n0));
    chk("abort idle", 32'(o_busy), 0);

    start_frame();
    feed(27, 1'b0);
    finish_frame("refresh", 1'b1);
    chk_tops("refresh", 26, 25, 24, 0, 0, 0);
    next_low("refresh");

`ifdef TOP3_SELECT_THRESH_EN
    for (int i = 0; i < 32; i++) sc[i] = (i < 10) ? i : -3;
    start_frame();
    feed(27, 1'b0);
    finish_frame("thr9", 1'b0);
    chk_tops("thr9", 26, 25, 24, 0, 0, 0);
    next_low("thr9");

    sc[20] = 10;
    start_frame();
    feed(27, 1'b0);
    finish_frame("thr10", 1'b1);
    chk_tops("thr10", 20, 9, 8, 26, 25, 24);
    next_low("thr10");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/top3_select.md
Name: top3_select

Overview:
- Streaming arg-top-3 stage between the classifier output layer and the dedup stage.
- Accepts one signed class score per valid cycle, N_CLASS scores per frame.
- Tracks the three highest-scoring class indices.
- On frame completion, presents current and previous top-3 index sets and pulses o_next to the dedup stage.

Parameters:
- N_CLASS, 27, classes per frame; legal range 3..32.
- SCORE_W, 16, signed score width.
- THRESH, 0, minimum top-0 score, signed SCORE_W; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-high
- i_start  in  1  begin new frame; honoured only in S_IDLE
- i_valid  in  1  i_score valid this cycle; honoured only in S_SCAN
- i_score  in  SCORE_W  signed score of class index = running count
- o_tops[0:2]  out  5 each  top-3 class indices of the latest frame, [0] = best
- o_prev_tops[0:2]  out  5 each  top-3 indices of the frame before the latest
- o_next  out  1  one-cycle pulse: o_tops/o_prev_tops just updated
- o_busy  out  1  high in S_SCAN and S_DONE

Behaviour:
- Reset (async, i_rst_n=1): state S_IDLE; o_tops, o_prev_tops all 0; o_next=0; o_busy=0; count=0; candidate scores = most-negative value; candidate indices = 0.
- S_IDLE:
  - i_start=1 -> clear candidates as at reset, count=0, go S_SCAN.
  - i_valid is ignored.
- S_SCAN, each cycle with i_valid=1:
  - Insert (i_score, count) into the sorted candidate list c0>=c1>=c2.
  - New entry displaces an entry only if strictly greater; ties keep the earlier index ahead.
  - Displaced entries shift down; c2 is dropped.
  - count increments.
  - When the accepted score has count==N_CLASS-1 -> go S_DONE.
  - i_valid=0 cycles stall with no change.
  - i_start is ignored.
- S_DONE, single cycle:
  - o_prev_tops <= o_tops.
  - o_tops <= candidate indices.
  - o_next <= 1.
  - go S_IDLE.
- o_next is registered and high for exactly one cycle, coincident with the new o_tops values.
- Latency: last score accepted at edge k -> o_next high during the cycle after edge k+1.
- i_start in the same cycle o_next is high is accepted, since state is already S_IDLE; back-to-back frames therefore cost one dead cycle.
- Reset mid-scan: everything returns to reset values immediately; the partial frame is discarded and no o_next is produced.
- Comparisons are signed and full SCORE_W; no saturation is required.
- Count width is 5 bits; count never wraps because N_CLASS<=32.

Optional Feature:
- Macro: TOP3_SELECT_THRESH_EN.
- Defined:
  - In S_DONE, if c0 score < THRESH (signed), the frame is rejected: o_tops and o_prev_tops are unchanged, o_next stays 0, and the FSM returns to S_IDLE.
  - Adds output o_reject (1 bit), a one-cycle pulse in place of o_next; reset value 0.
- Undefined:
  - Every completed frame updates outputs and pulses o_next.
  - THRESH is unused and o_reject is absent.

Decomposition:
- glove_pkg:
  - CLS_W=5
  - typedef logic [CLS_W-1:0] cls_idx_t
  - typedef logic signed [SCORE_W-1:0] score_t (default 16)
  - state enum S_IDLE/S_SCAN/S_DONE
- Sub-module top3_insert: purely combinational sorted-insertion network.
  - Inputs: three (score, index) candidates plus one new (score, index).
  - Outputs: the updated three candidates.
  - top3_select instantiates it once and registers its outputs.

Test Plan:
- Ascending scores 0..26 (class i score=i), N_CLASS=27 -> o_tops={26,25,24}; o_next one cycle; o_prev_tops={0,0,0}.
- Second frame, scores 100 at idx5, 90 at idx2, 80 at idx17, rest -50 -> o_tops={5,2,17}, o_prev_tops={26,25,24}.
- Tie frame, all scores 7 -> o_tops={0,1,2}, confirming earlier index wins ties.
- Random i_valid gaps (~50% duty) over the frame of the second case -> identical result; o_next exactly one cycle after the final accept + 1.
- Assert i_rst_n mid-scan after 10 scores, then run the full first frame -> outputs match the fresh first-frame case; no o_next from the aborted frame; i_start pulsed during S_SCAN has no effect.
- With TOP3_SELECT_THRESH_EN, THRESH=10, frame max score 9 -> o_reject pulses, o_next=0, o_tops unchanged; max score 10 -> accepted.
